// File: rtl/mem_stage.sv
// MEM pipeline stage: sized little-endian loads/stores on a local word memory, feeding MEM/WB.
// Optional macro MEM_MISALIGN_TRAP_EN adds misaligned-access suppression and the misalign output.
module mem_stage #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic [1:0]  wb_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  dest_reg,
   input  logic        stall,
   output logic [1:0]  mem_wb_wb_out,
   output logic [31:0] mem_wb_read_data,
   output logic [31:0] mem_wb_alu_result,
   output logic [4:0]  mem_wb_dest_reg
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } size_e;

   logic [31:0]       r_mem [DEPTH];
   logic [1:0]        r_wb;
   logic [31:0]       r_rdata;
   logic [31:0]       r_alu;
   logic [4:0]        r_dest;
   logic              r_mis;

   size_e             w_rd_sz;
   size_e             w_wr_sz;
   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic [31:0]       w_rd_word;
   logic [31:0]       w_wr_word;
   logic [31:0]       w_ld_data;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_ld_mis;
   logic              w_st_mis;
   logic              w_store;

   assign w_rd_sz   = size_e'(mem_read);
   assign w_wr_sz   = size_e'(mem_write);
   assign w_idx     = alu_result[ADDR_W+1:2];
   assign w_lane    = alu_result[1:0];
   assign w_rd_word = r_mem[w_idx];

`ifdef MEM_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
      return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
   endfunction

   assign w_ld_mis = is_misaligned(w_rd_sz, w_lane);
   assign w_st_mis = is_misaligned(w_wr_sz, w_lane);
   assign misalign = r_mis;
`else
   assign w_ld_mis = 1'b0;
   assign w_st_mis = 1'b0;
`endif

   assign w_store = !stall && (w_wr_sz != SZ_NONE) && !w_st_mis;

   always_comb begin
      w_byte = w_rd_word[7:0];
      case (w_lane)
         2'b00:   w_byte = w_rd_word[7:0];
         2'b01:   w_byte = w_rd_word[15:8];
         2'b10:   w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

      w_ld_data = '0;
      if (!w_ld_mis) begin
         case (w_rd_sz)
            SZ_BYTE: w_ld_data = {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_ld_data = {{16{w_half[15]}}, w_half};
            SZ_WORD: w_ld_data = w_rd_word;
            default: w_ld_data = '0;
         endcase
      end
   end

   // Merge the store operand into the current word so unselected lanes keep their value.
   always_comb begin
      w_wr_word = w_rd_word;
      case (w_wr_sz)
         SZ_BYTE: begin
            case (w_lane)
               2'b00:   w_wr_word[7:0]   = store_data[7:0];
               2'b01:   w_wr_word[15:8]  = store_data[7:0];
               2'b10:   w_wr_word[23:16] = store_data[7:0];
               default: w_wr_word[31:24] = store_data[7:0];
            endcase
         end
         SZ_HALF: begin
            if (w_lane[1]) w_wr_word[31:16] = store_data[15:0];
            else           w_wr_word[15:0]  = store_data[15:0];
         end
         SZ_WORD: w_wr_word = store_data;
         default: w_wr_word = w_rd_word;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_store) begin
         r_mem[w_idx] <= w_wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb    <= '0;
         r_rdata <= '0;
         r_alu   <= '0;
         r_dest  <= '0;
         r_mis   <= 1'b0;
      end else if (!stall) begin
         r_wb    <= w_ld_mis ? 2'b00 : wb_in;
         r_rdata <= w_ld_data;
         r_alu   <= alu_result;
         r_dest  <= dest_reg;
         r_mis   <= w_ld_mis || w_st_mis;
      end
   end

   assign mem_wb_wb_out     = r_wb;
   assign mem_wb_read_data  = r_rdata;
   assign mem_wb_alu_result = r_alu;
   assign mem_wb_dest_reg   = r_dest;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected MEM/WB contents, a monitor pops and compares.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mem_read = '0;
   logic [1:0]  mem_write = '0;
   logic [1:0]  wb_in = '0;
   logic [31:0] alu_result = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  dest_reg = '0;
   logic        stall = 1'b0;
   logic [1:0]  mem_wb_wb_out;
   logic [31:0] mem_wb_read_data;
   logic [31:0] mem_wb_alu_result;
   logic [4:0]  mem_wb_dest_reg;
   logic        mis_out;

   mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .wb_in             (wb_in),
      .alu_result        (alu_result),
      .store_data        (store_data),
      .dest_reg          (dest_reg),
      .stall             (stall),
      .mem_wb_wb_out     (mem_wb_wb_out),
      .mem_wb_read_data  (mem_wb_read_data),
      .mem_wb_alu_result (mem_wb_alu_result),
      .mem_wb_dest_reg   (mem_wb_dest_reg)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign          (mis_out)
`endif
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign mis_out = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dest;
      logic        mis;
   } exp_t;

   exp_t q[$];
   exp_t last_exp = '0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stalled cycles expect MEM/WB to hold whatever the previous capture produced.
   task automatic issue(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] wb,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dest,
                        input logic stl, input logic [31:0] exp_rd, input logic [1:0] exp_wb,
                        input logic exp_mis);
      exp_t e;
      @(negedge clk);
      mem_read   = rd;
      mem_write  = wr;
      wb_in      = wb;
      alu_result = addr;
      store_data = data;
      dest_reg   = dest;
      stall      = stl;
      if (stl) begin
         e = last_exp;
      end else begin
         e = '{wb: exp_wb, rd: exp_rd, alu: addr, dest: dest, mis: exp_mis};
         last_exp = e;
      end
      q.push_back(e);
   endtask

   task automatic idle_inputs();
      mem_read  = '0;
      mem_write = '0;
      wb_in     = '0;
      stall     = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && q.size() > 0) begin
            e = q.pop_front();
            check("read_data", mem_wb_read_data, e.rd);
            check("wb_out", {30'd0, mem_wb_wb_out}, {30'd0, e.wb});
            check("alu_result", mem_wb_alu_result, e.alu);
            check("dest_reg", {27'd0, mem_wb_dest_reg}, {27'd0, e.dest});
`ifdef MEM_MISALIGN_TRAP_EN
            check("misalign", {31'd0, mis_out}, {31'd0, e.mis});
`endif
         end
      end
   end

   initial begin : driver
      int waited;
      @(negedge clk);
      check("rst_read_data", mem_wb_read_data, 32'h0);
      check("rst_alu", mem_wb_alu_result, 32'h0);
      check("rst_wb_dest", {25'd0, mem_wb_wb_out, mem_wb_dest_reg}, 32'h0);
      check("rst_misalign", {31'd0, mis_out}, 32'h0);
      rst = 1'b0;

      //     rd     wr     wb     addr          data          dst  stl   exp_rd        exp_wb mis
      issue(2'b00, 2'b11, 2'b01, 32'h0000_0010, 32'h1234_5678, 5'd1, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b11, 2'b00, 2'b10, 32'h0000_0010, 32'h0,         5'd2, 1'b0, 32'h1234_5678, 2'b10, 1'b0);
      issue(2'b01, 2'b00, 2'b11, 32'h0000_0013, 32'h0,         5'd3, 1'b0, 32'h0000_0012, 2'b11, 1'b0);
      issue(2'b00, 2'b01, 2'b01, 32'h0000_0011, 32'hABCD_EF80, 5'd4, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b01, 2'b00, 2'b10, 32'h0000_0011, 32'h0,         5'd5, 1'b0, 32'hFFFF_FF80, 2'b10, 1'b0);
      issue(2'b11, 2'b00, 2'b11, 32'h0000_0010, 32'h0,         5'd6, 1'b0, 32'h1234_8078, 2'b11, 1'b0);
      issue(2'b01, 2'b00, 2'b01, 32'h0000_0012, 32'h0,         5'd7, 1'b0, 32'h0000_0034, 2'b01, 1'b0);
      issue(2'b00, 2'b10, 2'b10, 32'h0000_0022, 32'h1234_BEEF, 5'd8, 1'b0, 32'h0000_0000, 2'b10, 1'b0);
      issue(2'b10, 2'b00, 2'b11, 32'h0000_0022, 32'h0,         5'd9, 1'b0, 32'hFFFF_BEEF, 2'b11, 1'b0);
      issue(2'b10, 2'b00, 2'b01, 32'h0000_0020, 32'h0,         5'd10, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b11, 2'b00, 2'b10, 32'h0000_0020, 32'h0,         5'd11, 1'b0, 32'hBEEF_0000, 2'b10, 1'b0);
      // stalled store with a load: MEM/WB must hold the previous capture
      issue(2'b11, 2'b11, 2'b11, 32'h0000_0040, 32'hAAAA_5555, 5'd12, 1'b1, 32'h0,         2'b00, 1'b0);
      issue(2'b11, 2'b11, 2'b01, 32'h0000_0040, 32'h1111_1111, 5'd13, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b11, 2'b00, 2'b10, 32'h0000_0040, 32'h0,         5'd14, 1'b0, 32'h1111_1111, 2'b10, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
      issue(2'b00, 2'b11, 2'b11, 32'h0000_0042, 32'hDEAD_BEEF, 5'd15, 1'b0, 32'h0000_0000, 2'b11, 1'b1);
      issue(2'b11, 2'b00, 2'b01, 32'h0000_0040, 32'h0,         5'd16, 1'b0, 32'h1111_1111, 2'b01, 1'b0);
      issue(2'b10, 2'b00, 2'b11, 32'h0000_0043, 32'h0,         5'd17, 1'b0, 32'h0000_0000, 2'b00, 1'b1);
      issue(2'b10, 2'b00, 2'b10, 32'h0000_0022, 32'h0,         5'd18, 1'b0, 32'hFFFF_BEEF, 2'b10, 1'b0);
`else
      issue(2'b10, 2'b00, 2'b11, 32'h0000_0023, 32'h0,         5'd15, 1'b0, 32'hFFFF_BEEF, 2'b11, 1'b0);
      issue(2'b11, 2'b00, 2'b01, 32'h0000_0013, 32'h0,         5'd16, 1'b0, 32'h1234_8078, 2'b01, 1'b0);
`endif
      issue(2'b00, 2'b11, 2'b01, 32'h0000_0400, 32'hCAFE_F00D, 5'd19, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b11, 2'b00, 2'b10, 32'h0000_0000, 32'h0,         5'd20, 1'b0, 32'hCAFE_F00D, 2'b10, 1'b0);

      // store presented, then reset asserted before its clock edge
      @(negedge clk);
      mem_read   = 2'b00;
      mem_write  = 2'b11;
      wb_in      = 2'b11;
      alu_result = 32'h0000_0044;
      store_data = 32'h5A5A_5A5A;
      dest_reg   = 5'd21;
      #2 rst = 1'b1;
      #1;
      check("midrst_read_data", mem_wb_read_data, 32'h0);
      check("midrst_alu", mem_wb_alu_result, 32'h0);
      check("midrst_wb_dest", {25'd0, mem_wb_wb_out, mem_wb_dest_reg}, 32'h0);
      check("midrst_misalign", {31'd0, mis_out}, 32'h0);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      last_exp = '0;

      issue(2'b11, 2'b00, 2'b01, 32'h0000_0044, 32'h0,         5'd22, 1'b0, 32'h0000_0000, 2'b01, 1'b0);
      issue(2'b11, 2'b00, 2'b10, 32'h0000_0000, 32'h0,         5'd23, 1'b0, 32'h0000_0000, 2'b10, 1'b0);
      issue(2'b11, 2'b00, 2'b11, 32'h0000_0010, 32'h0,         5'd24, 1'b0, 32'h0000_0000, 2'b11, 1'b0);

      @(negedge clk);
      idle_inputs();
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
